// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, alu operand/result bus and debug read port for alu_issue_ctrl.
// The slave modport is the controller; the master modport is the issuing agent/alu side.
interface alu_issue_ctrl_if #(
  parameter int WORD_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 2
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic                      instr_load;
  logic                      instr_imm_en;
  logic [OPCODE_WIDTH-1:0]   instr_op;
  logic [REG_ADDR_WIDTH-1:0] instr_rd;
  logic [REG_ADDR_WIDTH-1:0] instr_rs1;
  logic [REG_ADDR_WIDTH-1:0] instr_rs2;
  logic [WORD_WIDTH-1:0]     instr_imm;
  logic [WORD_WIDTH-1:0]     operand1;
  logic [WORD_WIDTH-1:0]     operand2;
  logic [OPCODE_WIDTH-1:0]   opCode;
  logic [WORD_WIDTH-1:0]     alu_result;
  logic                      alu_zero;
  logic                      done;
  logic                      zero_flag;
  logic [REG_ADDR_WIDTH-1:0] dbg_addr;
  logic [WORD_WIDTH-1:0]     dbg_data;

  modport master (
    output instr_valid, instr_load, instr_imm_en, instr_op, instr_rd, instr_rs1,
           instr_rs2, instr_imm, alu_result, alu_zero, dbg_addr,
    input  instr_ready, operand1, operand2, opCode, done, zero_flag, dbg_data
  );

  modport slave (
    input  instr_valid, instr_load, instr_imm_en, instr_op, instr_rd, instr_rs1,
           instr_rs2, instr_imm, alu_result, alu_zero, dbg_addr,
    output instr_ready, operand1, operand2, opCode, done, zero_flag, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around a combinational alu: reads a small register file,
// presents registered operands for one settle cycle, writes the result back, pulses done.
module alu_issue_ctrl #(
  parameter int WORD_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 4,
  parameter int NUM_REGS       = 4,
  parameter int REG_ADDR_WIDTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  alu_issue_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                w_next_state;
  logic [WORD_WIDTH-1:0]     r_regs [NUM_REGS];
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [WORD_WIDTH-1:0]     r_operand1;
  logic [WORD_WIDTH-1:0]     r_operand2;
  logic [OPCODE_WIDTH-1:0]   r_opcode;
  logic                      r_done;
  logic                      r_zero_flag;
  logic                      w_instr_ready;
  logic                      w_accept;
  logic                      w_wr_en;
  logic [REG_ADDR_WIDTH-1:0] w_wr_addr;
  logic [WORD_WIDTH-1:0]     w_wr_data;

  assign w_instr_ready   = rst_n && (r_state == S_IDLE);
  assign w_accept        = bus.instr_valid && w_instr_ready;
  assign bus.instr_ready = w_instr_ready;
  assign bus.operand1    = r_operand1;
  assign bus.operand2    = r_operand2;
  assign bus.opCode      = r_opcode;
  assign bus.done        = r_done;
  assign bus.zero_flag   = r_zero_flag;
  assign bus.dbg_data    = r_regs[bus.dbg_addr];

  // Next-state decode: loads skip EXEC since they never touch the alu.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = bus.instr_load ? S_WB : S_EXEC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Register-file write port select: immediate load at accept, alu result at EXEC exit.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_rd;
    w_wr_data = bus.alu_result;
    case (r_state)
      S_IDLE: begin
        if (w_accept && bus.instr_load) begin
          w_wr_en   = 1'b1;
          w_wr_addr = bus.instr_rd;
          w_wr_data = bus.instr_imm;
        end else begin
          w_wr_en   = 1'b0;
        end
      end
      S_EXEC:  w_wr_en = 1'b1;
      default: w_wr_en = 1'b0;
    endcase
  end

  // State register and done pulse, asserted for the single cycle spent in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == S_WB);
    end
  end

  // Register file storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {WORD_WIDTH{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // Operand capture for alu ops; outputs hold their values across loads and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand1 <= {WORD_WIDTH{1'b0}};
      r_operand2 <= {WORD_WIDTH{1'b0}};
      r_opcode   <= {OPCODE_WIDTH{1'b0}};
      r_rd       <= {REG_ADDR_WIDTH{1'b0}};
    end else if (w_accept && !bus.instr_load) begin
      r_operand1 <= r_regs[bus.instr_rs1];
      r_operand2 <= bus.instr_imm_en ? bus.instr_imm : r_regs[bus.instr_rs2];
      r_opcode   <= bus.instr_op;
      r_rd       <= bus.instr_rd;
    end
  end

  // Zero flag is sticky across loads; only an alu writeback updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_flag <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_zero_flag <= bus.alu_zero;
    end
  end

endmodule
